// File: rtl/readback_pkg.sv
// Shared types and constants for the eFPGA readback byte transmitter.
// READBACK_CHECKSUM_EN adds the CSUM state to the encoding.
package readback_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         BYTE_IDX_W        = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA
`ifdef READBACK_CHECKSUM_EN
    , CSUM
`endif
  } state_e;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [7:0] word_byte(input logic [31:0]           word,
                                           input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = word[31:24];
      2'd1: b = word[23:16];
      2'd2: b = word[15:8];
      2'd3: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/readback_word_fifo.sv
// Word FIFO between the eFPGA readback port and the byte serializer.
// A push is accepted while full when a pop happens in the same cycle.
module readback_word_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem[rd_q[AW-1:0]];

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/efpga_readback_tx.sv
// Serializes eFPGA readback words into SYNC/LEN/DATA[/CSUM] byte packets.
// Define READBACK_CHECKSUM_EN to append an XOR checksum byte.
module efpga_readback_tx
  import readback_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  word_count_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i
);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, acc_q, left_q;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic [31:0]           word_q, fifo_head;
  logic [7:0]            data_d;
  logic                  valid_d, done_d;
  logic                  hs, start_ok, last_word, word_end;
  logic                  push, pop, fifo_full, fifo_empty;
`ifdef READBACK_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign hs           = in_valid_o && in_ready_i;
  assign start_ok     = (state_q == IDLE) && start_i && (word_count_i != 8'd0) && !done_o;
  assign last_word    = (left_q == 8'd1);
  assign word_end     = (state_q == DATA) && hs && (idx_q == '1);
  assign idx_inc      = idx_q + 1'b1;
  assign busy_o       = (state_q != IDLE);
  assign word_ready_o = busy_o && !fifo_full && (acc_q < cnt_q);
  assign push         = word_valid_i && word_ready_o;
  assign pop          = (state_q == DATA) && hs && (idx_q == '0);

  readback_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (word_data_i),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = SYNC;
      SYNC: if (hs) state_d = LEN;
      LEN:  if (hs) state_d = DATA;
      DATA: if (word_end && last_word) begin
`ifdef READBACK_CHECKSUM_EN
        state_d = CSUM;
`else
        state_d = IDLE;
`endif
      end
`ifdef READBACK_CHECKSUM_EN
      CSUM: if (hs) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered byte stream; the output register reloads
  // on its own handshake, which gives one byte per cycle with no bubble.
  always_comb begin
    valid_d = in_valid_o;
    data_d  = in_data_o;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start_ok) begin
        valid_d = 1'b1;
        data_d  = SYNC_BYTE;
      end
      SYNC: if (hs) data_d = cnt_q;
      LEN: if (hs) begin
        idx_d   = '0;
        valid_d = !fifo_empty;
        if (!fifo_empty) data_d = word_byte(fifo_head, '0);
      end
      DATA: begin
        if (!in_valid_o) begin
          // Waiting for the next word; only byte 0 can ever be starved.
          if (!fifo_empty) begin
            valid_d = 1'b1;
            data_d  = word_byte(fifo_head, '0);
          end
        end else if (hs) begin
          if (idx_q != '1) begin
            idx_d  = idx_inc;
            data_d = word_byte((idx_q == '0) ? fifo_head : word_q, idx_inc);
          end else if (last_word) begin
`ifdef READBACK_CHECKSUM_EN
            data_d  = csum_q ^ in_data_o;
`else
            valid_d = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = '0;
            valid_d = !fifo_empty;
            if (!fifo_empty) data_d = word_byte(fifo_head, '0);
          end
        end
      end
`ifdef READBACK_CHECKSUM_EN
      CSUM: if (hs) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_valid_o <= 1'b0;
      in_data_o  <= 8'h00;
      done_o     <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= 8'd0;
      acc_q      <= 8'd0;
      left_q     <= 8'd0;
      word_q     <= 32'd0;
`ifdef READBACK_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      in_valid_o <= valid_d;
      in_data_o  <= data_d;
      done_o     <= done_d;
      idx_q      <= idx_d;
      if (start_ok) begin
        cnt_q  <= word_count_i;
        acc_q  <= 8'd0;
        left_q <= word_count_i;
`ifdef READBACK_CHECKSUM_EN
        csum_q <= word_count_i;
`endif
      end else begin
        if (push)     acc_q  <= acc_q + 1'b1;
        if (word_end) left_q <= left_q - 1'b1;
        if (pop)      word_q <= fifo_head;
`ifdef READBACK_CHECKSUM_EN
        if ((state_q == DATA) && hs) csum_q <= csum_q ^ in_data_o;
`endif
      end
    end
  end

endmodule

// File: tb/tb_efpga_readback_tx.sv
// Scoreboard bench for efpga_readback_tx: packets are modelled as byte lists,
// a monitor compares every byte handshake and the end-of-packet conditions.
module tb_efpga_readback_tx;

  localparam logic [7:0] SYNC_TB = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [7:0]  word_count_i;
  logic        busy_o, done_o;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;

  efpga_readback_tx #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .start_i      (start_i),
    .word_count_i (word_count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .word_data_i  (word_data_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .in_data_o    (in_data_o),
    .in_valid_o   (in_valid_o),
    .in_ready_i   (in_ready_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ready_mode = 0;
  int          pushes = 0, exp_count = 0, gap_cycles = 0;
  int          hs_total = 0, done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] feed_q[$];
  int          gap_q[$];
  int          hs_cyc_q[$];
  logic [31:0] pkt_words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink readiness: 0 = always ready, 1 = alternating 1010, 2 = random
  initial begin
    in_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       in_ready_i = (cyc % 2) == 0;
        2:       in_ready_i = ($urandom_range(0, 3) != 0);
        default: in_ready_i = 1'b1;
      endcase
    end
  end

  // Word source: packet words with optional per-word delay, then junk words
  // offered continuously so any over-acceptance is visible.
  initial begin
    int dly;
    bit took, real_word;
    dly = 0; real_word = 1'b0;
    word_valid_i = 1'b0; word_data_i = 32'd0;
    forever begin
      @(negedge clk);
      took = word_valid_i && word_ready_o && reset_n_i;
      @(posedge clk); #1;
      if (took && real_word && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        if (gap_q.size() > 0) void'(gap_q.pop_front());
        dly = (gap_q.size() > 0) ? gap_q[0] : 0;
      end
      if (feed_q.size() == 0) dly = 0;
      if (feed_q.size() > 0 && dly > 0) begin
        dly--;
        word_valid_i = 1'b0;
        real_word    = 1'b0;
      end else if (feed_q.size() > 0) begin
        word_valid_i = 1'b1;
        word_data_i  = feed_q[0];
        real_word    = 1'b1;
      end else begin
        word_valid_i = 1'b1;
        word_data_i  = $urandom;
        real_word    = 1'b0;
      end
    end
  end

  // Monitor: byte scoreboard, hold-while-stalled, end-of-packet checks
  initial begin
    bit         prev_stall, prev_done;
    logic [7:0] prev_data;
    prev_stall = 1'b0; prev_done = 1'b0; prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(in_valid_o), 32'd1);
        check("hold_data", 32'(in_data_o), 32'(prev_data));
      end
      if (word_valid_i && word_ready_o) pushes++;
      if (busy_o && !in_valid_o) gap_cycles++;
      if (in_valid_o && in_ready_i) begin
        hs_total++;
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected no byte (cycle %0d)", in_data_o, cyc);
        end else begin
          check("byte", 32'(in_data_o), 32'(exp_q.pop_front()));
        end
      end
      if (done_o) begin
        check("done_single_pulse", 32'(prev_done), 32'd0);
        check("done_busy_low", 32'(busy_o), 32'd0);
        check("done_bytes_left", 32'(exp_q.size()), 32'd0);
        check("done_words_accepted", 32'(pushes), 32'(exp_count));
        done_cnt++;
      end
      prev_done  = done_o;
      prev_stall = in_valid_o && !in_ready_i;
      prev_data  = in_data_o;
    end
  end

  // Reference model: SYNC, LEN, words MSB-first, optional XOR checksum
  task automatic begin_packet(input int count, input int gap_word, input int gap_len);
    logic [31:0] w;
    logic [7:0]  b, cs, cnt8;
    cnt8 = count[7:0];
    hs_cyc_q.delete();
    pushes = 0; gap_cycles = 0; exp_count = count;
    exp_q.push_back(SYNC_TB);
    exp_q.push_back(cnt8);
    cs = cnt8;
    for (int i = 0; i < count; i++) begin
      w = pkt_words[i];
      feed_q.push_back(w);
      gap_q.push_back((i == gap_word) ? gap_len : 0);
      for (int k = 3; k >= 0; k--) begin
        b = 8'(w >> (8 * k));
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
`ifdef READBACK_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    start_i = 1'b1; word_count_i = cnt8;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done(input bit start_on_done);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (seen && start_on_done) begin
      start_i = 1'b1; word_count_i = 8'd3;
      @(posedge clk); #1;
      start_i = 1'b0;
      check("start_on_done_ignored", 32'(busy_o), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int done_exp, base_hs, base_done, cnt;
    reset_n_i = 1'b0; start_i = 1'b0; word_count_i = 8'd0;
    done_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_in_valid", 32'(in_valid_o), 32'd0);
    check("rst_word_ready", 32'(word_ready_o), 32'd0);
    check("rst_in_data", 32'(in_data_o), 32'h00);
    reset_n_i = 1'b1;
    @(posedge clk); #1;

    // Single word at full rate: six bytes on consecutive cycles
    ready_mode = 0;
    pkt_words = '{32'h11223344};
    begin_packet(1, -1, 0);
    wait_done(1'b0); done_exp++;
    check("t1_byte_count", 32'(hs_cyc_q.size()), 32'd6);
    if (hs_cyc_q.size() == 6) check("t1_back_to_back", 32'(hs_cyc_q[5] - hs_cyc_q[0]), 32'd5);

    // Alternating sink readiness, three words
    ready_mode = 1;
    pkt_words = '{32'hDEADBEEF, 32'h0BADF00D, 32'hCAFE1234};
    begin_packet(3, -1, 0);
    wait_done(1'b0); done_exp++;

    // Second word delayed 20 cycles; junk third word must be refused
    ready_mode = 0;
    pkt_words = '{32'hA1B2C3D4, 32'h55667788};
    begin_packet(2, 1, 20);
    wait_done(1'b0); done_exp++;
    check("t3_valid_low_in_gap", 32'(gap_cycles >= 10), 32'd1);

    // Zero-count start in IDLE is ignored
    start_i = 1'b1; word_count_i = 8'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("zero_count_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check("zero_count_valid", 32'(in_valid_o), 32'd0);

    // Start while busy and start in the done cycle are ignored
    ready_mode = 2;
    pkt_words = '{32'h01020304, 32'hF0E1D2C3, 32'h8899AABB};
    begin_packet(3, -1, 0);
    repeat (4) @(posedge clk);
    #1;
    start_i = 1'b1; word_count_i = 8'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("start_while_busy", 32'(busy_o), 32'd1);
    wait_done(1'b1); done_exp++;

    // Reset after the LEN byte aborts the packet without done_o
    ready_mode = 0;
    pkt_words = '{32'h13579BDF, 32'h2468ACE0, 32'h0F0F0F0F};
    base_hs = hs_total;
    base_done = done_cnt;
    begin_packet(3, -1, 0);
    for (int i = 0; i < 200 && hs_total < base_hs + 2; i++) begin
      @(posedge clk); #1;
    end
    check("abort_reached_len", 32'(hs_total - base_hs), 32'd2);
    reset_n_i = 1'b0;
    exp_q.delete(); feed_q.delete(); gap_q.delete();
    #2;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_in_valid", 32'(in_valid_o), 32'd0);
    check("abort_word_ready", 32'(word_ready_o), 32'd0);
    check("abort_in_data", 32'(in_data_o), 32'h00);
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", 32'(done_cnt), 32'(base_done));
    pkt_words = '{32'h01020304};
    begin_packet(1, -1, 0);
    wait_done(1'b0); done_exp++;

    // Randomized packets, lengths past the FIFO depth, random stalls
    for (int p = 0; p < 10; p++) begin
      cnt = $urandom_range(1, 9);
      ready_mode = (p % 3 == 0) ? 0 : 2;
      pkt_words.delete();
      for (int i = 0; i < cnt; i++) pkt_words.push_back($urandom);
      begin_packet(cnt, $urandom_range(0, cnt - 1), $urandom_range(0, 6));
      wait_done(1'b0); done_exp++;
    end

    check("total_done_pulses", 32'(done_cnt), 32'(done_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
